// File: rtl/data_stage_param.sv
// data_stage_param: register file, write-back mux, immediate generator with
// upper-immediate latch, and the A/B/IMM operand latches feeding the ALU.
// Writes and operand loads share an edge; a read of the register being written
// sees the new value (write-through bypass).
module data_stage_param #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    localparam int ADDR_W  = $clog2(NUM_REGS),
    parameter int IMM_W    = 7,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] input_reg_readA_address,
    input  logic [ADDR_W-1:0] input_reg_readB_address,
    input  logic              input_reg_write,
    input  logic [ADDR_W-1:0] input_reg_write_address,
    input  logic [1:0]        input_wb_sel,
    input  logic [DATA_W-1:0] input_ALUOut,
    input  logic [DATA_W-1:0] input_MDR,
    input  logic [DATA_W-1:0] input_link,
    input  logic [DATA_W-1:0] input_imm,
    input  logic [1:0]        input_imm_sel,
    input  logic              input_latch_en,
    output logic [DATA_W-1:0] output_reg_A,
    output logic [DATA_W-1:0] output_reg_B,
    output logic [DATA_W-1:0] output_imm,
    output logic [DATA_W-1:0] output_wb_data
);

    localparam int U_W = DATA_W - IMM_W;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MDR  = 2'b01,
        WB_LINK = 2'b10,
        WB_IMM  = 2'b11
    } wb_sel_t;

    typedef enum logic [1:0] {
        IMM_SEXT = 2'b00,
        IMM_ZEXT = 2'b01,
        IMM_LUI  = 2'b10,
        IMM_UCAT = 2'b11
    } imm_sel_t;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [U_W-1:0]    ui_q;
    logic [DATA_W-1:0] imm_next;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              write_eff;

    // Only some bits of the raw immediate feed any given mode.
    logic imm_unused;
    assign imm_unused = ^input_imm;

    // Immediate generator: extend or place the raw field according to the mode.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        imm_next = '0;
        unique case (imm_sel_t'(input_imm_sel))
            IMM_SEXT: imm_next = {{U_W{input_imm[IMM_W-1]}}, input_imm[IMM_W-1:0]};
            IMM_ZEXT: imm_next = {{U_W{1'b0}}, input_imm[IMM_W-1:0]};
            IMM_LUI:  imm_next = {input_imm[U_W-1:0], {IMM_W{1'b0}}};
            IMM_UCAT: imm_next = {ui_q, input_imm[IMM_W-1:0]};
            default:  imm_next = '0;
        endcase
    end

    // Write-back source select; the immediate source is the live one, not the latched one.
    always_comb begin
        output_wb_data = '0;
        unique case (wb_sel_t'(input_wb_sel))
            WB_ALU:  output_wb_data = input_ALUOut;
            WB_MDR:  output_wb_data = input_MDR;
            WB_LINK: output_wb_data = input_link;
            WB_IMM:  output_wb_data = imm_next;
            default: output_wb_data = '0;
        endcase
    end

    // A write to the hardwired zero register is dropped and therefore never bypasses.
    assign write_eff = input_reg_write &&
                       !((ZERO_REG != 0) && (input_reg_write_address == '0));

    // Read ports: zero register, then same-edge bypass, then stored value.
    always_comb begin
        rd_a = regs[input_reg_readA_address];
        rd_b = regs[input_reg_readB_address];
        if ((ZERO_REG != 0) && (input_reg_readA_address == '0)) begin
            rd_a = '0;
        end else if (write_eff && (input_reg_write_address == input_reg_readA_address)) begin
            rd_a = output_wb_data;
        end
        if ((ZERO_REG != 0) && (input_reg_readB_address == '0)) begin
            rd_b = '0;
        end else if (write_eff && (input_reg_write_address == input_reg_readB_address)) begin
            rd_b = output_wb_data;
        end
    end

    // Register file storage.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            // NOTE: the register file is reset on purpose; software relies on every register reading 0 after reset.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_eff) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            regs[input_reg_write_address] <= output_wb_data;
        end
    end

    // Upper-immediate latch: captured by LUI, consumed (cleared) by UCAT.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ui_q <= '0;
        end else if (input_latch_en) begin
            if (imm_sel_t'(input_imm_sel) == IMM_LUI) begin
                ui_q <= input_imm[U_W-1:0];
            end else if (imm_sel_t'(input_imm_sel) == IMM_UCAT) begin
                ui_q <= '0;
            end
        end
    end

    // Operand latches presented to the ALU one edge after addresses are valid.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            output_reg_A <= '0;
            output_reg_B <= '0;
            output_imm   <= '0;
        end else if (input_latch_en) begin
            output_reg_A <= rd_a;
            output_reg_B <= rd_b;
            output_imm   <= imm_next;
        end
    end

endmodule
